// File: rtl/sr_ctrl.sv
// Status-register controller: arbitrates ALU, software, interrupt-entry and
// interrupt-return updates of the status value, with a shadow stack for nesting.
module sr_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned IMASK_BIT = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_req,
    input  logic [WIDTH-1:0]         alu_mask,
    input  logic [WIDTH-1:0]         alu_flags,
    output logic                     alu_gnt,
    input  logic                     sw_req,
    input  logic [WIDTH-1:0]         sw_data,
    output logic                     sw_gnt,
    input  logic                     ent_req,
    output logic                     ent_gnt,
    input  logic                     ret_req,
    output logic                     ret_gnt,
    output logic [WIDTH-1:0]         sr_set,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     ovf,
    output logic                     unf,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = AW + 1;
    localparam logic [WIDTH-1:0] IMASK = WIDTH'(1) << IMASK_BIT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        RETURN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] sr_nxt;
    logic [WIDTH-1:0] alu_m;
    logic [DW-1:0]    depth_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             push;
    logic             full;
    logic             empty;

    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);
    assign alu_m = alu_mask & ~IMASK;
    assign busy  = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Arbitration, next state and datapath updates; grants only in IDLE, never during reset
    always_comb begin
        state_nxt = state;
        sr_nxt    = sr_set;
        depth_nxt = depth;
        ovf_nxt   = ovf;
        unf_nxt   = unf;
        push      = 1'b0;
        alu_gnt   = 1'b0;
        sw_gnt    = 1'b0;
        ent_gnt   = 1'b0;
        ret_gnt   = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (ret_req) begin
                        ret_gnt = 1'b1;
                        if (!empty) begin
                            depth_nxt = depth - DW'(1);
                            state_nxt = RETURN;
                        end else begin
                            unf_nxt = 1'b1;
                        end
                    end else if (ent_req) begin
                        ent_gnt   = 1'b1;
                        state_nxt = ENTER;
                        if (!full) begin
                            push      = 1'b1;
                            depth_nxt = depth + DW'(1);
                        end else begin
                            ovf_nxt = 1'b1;
                        end
                    end else if (sw_req) begin
                        sw_gnt = 1'b1;
                        sr_nxt = sw_data;
                    end else if (alu_req) begin
                        alu_gnt = 1'b1;
                        sr_nxt  = (sr_set & ~alu_m) | (alu_flags & alu_m);
                    end
                end
            end
            ENTER: begin
                sr_nxt    = sr_set | IMASK;
                state_nxt = IDLE;
            end
            RETURN: begin
                // depth already holds the post-decrement index here
                sr_nxt    = stack[depth[AW-1:0]];
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Architectural status, occupancy and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_set <= '0;
            depth  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            sr_set <= sr_nxt;
            depth  <= depth_nxt;
            ovf    <= ovf_nxt;
            unf    <= unf_nxt;
        end
    end

    // Shadow stack storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (push) stack[depth[AW-1:0]] <= sr_set;
    end

endmodule
